// File: rtl/axis_extract_header_pkg.sv
// Shared stream types and byte-mask helpers for the header extractor.
// Byte 0 of a beat is the MSB lane, i.e. the first byte on the wire.
package axis_extract_header_pkg;

  localparam int unsigned DATA_WD      = 32;
  localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

  typedef logic [BYTE_CNT_WD:0]    cnt_t;
  typedef logic [DATA_BYTE_WD-1:0] keep_t;
  typedef logic [DATA_WD-1:0]      data_t;

  typedef struct packed {
    data_t data;
    keep_t keep;
    logic  last;
  } beat_t;

  typedef enum logic [1:0] {StIdle, StBody, StFlush} state_e;

  function automatic keep_t msb_mask(cnt_t cnt);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      if (cnt_t'(i) < cnt) m[DATA_BYTE_WD-1-i] = 1'b1;
    end
    return m;
  endfunction

  function automatic keep_t lsb_mask(cnt_t cnt);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      if (cnt_t'(i) < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic cnt_t popcount(keep_t keep);
    cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + cnt_t'(keep[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_extract_header_if.sv
// Bundle of the length-token, input stream, payload stream and header channel.
interface axis_extract_header_if;
  import axis_extract_header_pkg::*;

  logic  valid_len_i;
  cnt_t  len_i;
  logic  ready_len_o;
  logic  valid_in;
  data_t data_in;
  keep_t keep_in;
  logic  last_in;
  logic  ready_in;
  logic  valid_out;
  data_t data_out;
  keep_t keep_out;
  logic  last_out;
  logic  ready_out;
  logic  valid_hdr_o;
  data_t data_hdr_o;
  keep_t keep_hdr_o;
  logic  ready_hdr_i;
  logic  err_short_o;

  modport master (
    output valid_len_i, len_i, valid_in, data_in, keep_in, last_in, ready_out, ready_hdr_i,
    input  ready_len_o, ready_in, valid_out, data_out, keep_out, last_out,
           valid_hdr_o, data_hdr_o, keep_hdr_o, err_short_o
  );

  modport slave (
    input  valid_len_i, len_i, valid_in, data_in, keep_in, last_in, ready_out, ready_hdr_i,
    output ready_len_o, ready_in, valid_out, data_out, keep_out, last_out,
           valid_hdr_o, data_hdr_o, keep_hdr_o, err_short_o
  );

endinterface

// File: rtl/axis_reg_slice.sv
// One-entry registered valid/ready slice; full throughput when the sink is ready.
module axis_reg_slice
  import axis_extract_header_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  valid_i,
  input  beat_t beat_i,
  output logic  ready_o,
  output logic  valid_o,
  output beat_t beat_o,
  input  logic  ready_i
);

  logic  valid_q;
  beat_t beat_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign beat_o  = beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) beat_q <= beat_i;
    end
  end

endmodule

// File: rtl/axis_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each packet and realigns the payload.
// The residue register holds the unsent low bytes of the previous beat, MSB-aligned.
module axis_extract_header
  import axis_extract_header_pkg::*;
(
  input logic clk,
  input logic rst_n,
  axis_extract_header_if.slave bus
);

  localparam cnt_t FullCnt = cnt_t'(DATA_BYTE_WD);

  state_e state_q, state_d;
  cnt_t   hlen_q, hlen_d;
  cnt_t   fcnt_q, fcnt_d;
  data_t  res_q, res_d;
  logic   hdr_valid_q, hdr_valid_d;
  data_t  hdr_data_q, hdr_data_d;
  keep_t  hdr_keep_q, hdr_keep_d;
  logic   err_q, err_d;

  logic   rdy, hdr_free, fire, short_pkt;
  cnt_t   n, hcnt;
  logic   pay_valid, pay_ready, out_valid;
  beat_t  pay_beat, out_beat;

  assign n        = popcount(bus.keep_in);
  assign hdr_free = !hdr_valid_q || bus.ready_hdr_i;
  assign fire     = bus.valid_in && rdy;

  // Never looks at valid_in: a length token is taken together with the first beat.
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      StIdle:  rdy = bus.valid_len_i && hdr_free && pay_ready;
      StBody:  rdy = pay_ready;
      default: rdy = 1'b0;
    endcase
  end

  assign bus.ready_in    = rdy;
  assign bus.ready_len_o = (state_q == StIdle) && rdy;

  always_comb begin
    state_d     = state_q;
    hlen_d      = hlen_q;
    fcnt_d      = fcnt_q;
    res_d       = res_q;
    hdr_valid_d = hdr_valid_q && !bus.ready_hdr_i;
    hdr_data_d  = hdr_data_q;
    hdr_keep_d  = hdr_keep_q;
    err_d       = 1'b0;
    pay_valid   = 1'b0;
    pay_beat    = '0;
    short_pkt   = bus.last_in && (n <= bus.len_i);
    hcnt        = short_pkt ? n : bus.len_i;

    case (state_q)
      StIdle: begin
        if (fire) begin
          hdr_valid_d = 1'b1;
          hdr_data_d  = bus.data_in >> {FullCnt - hcnt, 3'b000};
          hdr_keep_d  = lsb_mask(hcnt);
          hlen_d      = bus.len_i;
          res_d       = bus.data_in << {bus.len_i, 3'b000};
          if (!bus.last_in) begin
            state_d = StBody;
          end else if (short_pkt) begin
            err_d = 1'b1;
          end else begin
            fcnt_d  = n - bus.len_i;
            state_d = StFlush;
          end
        end
      end
      StBody: begin
        pay_valid     = bus.valid_in;
        pay_beat.data = res_q | (bus.data_in >> {FullCnt - hlen_q, 3'b000});
        pay_beat.keep = '1;
        if (bus.last_in && (n <= hlen_q)) begin
          pay_beat.keep = msb_mask(FullCnt - hlen_q + n);
          pay_beat.last = 1'b1;
        end
        if (fire) begin
          res_d = bus.data_in << {hlen_q, 3'b000};
          if (bus.last_in) begin
            if (n <= hlen_q) begin
              state_d = StIdle;
            end else begin
              fcnt_d  = n - hlen_q;
              state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        pay_valid     = 1'b1;
        pay_beat.data = res_q;
        pay_beat.keep = msb_mask(fcnt_q);
        pay_beat.last = 1'b1;
        if (pay_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hlen_q      <= '0;
      fcnt_q      <= '0;
      res_q       <= '0;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hlen_q      <= hlen_d;
      fcnt_q      <= fcnt_d;
      res_q       <= res_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_data_q  <= hdr_data_d;
      hdr_keep_q  <= hdr_keep_d;
      err_q       <= err_d;
    end
  end

  axis_reg_slice u_pay_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (pay_valid),
    .beat_i  (pay_beat),
    .ready_o (pay_ready),
    .valid_o (out_valid),
    .beat_o  (out_beat),
    .ready_i (bus.ready_out)
  );

  assign bus.valid_out   = out_valid;
  assign bus.data_out    = out_beat.data;
  assign bus.keep_out    = out_beat.keep;
  assign bus.last_out    = out_beat.last;
  assign bus.valid_hdr_o = hdr_valid_q;
  assign bus.data_hdr_o  = hdr_data_q;
  assign bus.keep_hdr_o  = hdr_keep_q;
  assign bus.err_short_o = err_q;

endmodule

// File: tb/tb_axis_extract_header.sv
// Scoreboard bench: a byte-level packet model predicts header and payload beats,
// and a negedge monitor pops and compares them as the DUT hands them over.
module tb_axis_extract_header;
  import axis_extract_header_pkg::*;

  typedef struct {
    data_t data;
    keep_t keep;
  } hdr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_extract_header_if bus ();

  axis_extract_header dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t      exp_pay[$];
  hdr_t       exp_hdr[$];
  logic [7:0] pkt[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         err_exp = 0;
  int         err_seen = 0;
  bit         chk_en = 1'b0;
  bit         rand_rdy = 1'b0;

  beat_t      held_pay, cur_pay, e_pay;
  hdr_t       held_hdr, e_hdr;
  bit         pay_stall = 1'b0;
  bit         hdr_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Header = first min(H, L) bytes right-aligned; payload = the rest, packed MSB-first.
  function automatic void model(input int h);
    int   l, hc, k;
    hdr_t hd;
    beat_t b;
    l  = pkt.size();
    hc = (l <= h) ? l : h;
    if (l <= h) err_exp++;
    hd.data = '0;
    hd.keep = '0;
    for (int i = 0; i < hc; i++) begin
      hd.data = (hd.data << 8) | data_t'(pkt[i]);
      hd.keep = {hd.keep[DATA_BYTE_WD-2:0], 1'b1};
    end
    exp_hdr.push_back(hd);
    b = '0;
    k = 0;
    for (int i = hc; i < l; i++) begin
      b.data[8*(DATA_BYTE_WD-1-k) +: 8] = pkt[i];
      b.keep[DATA_BYTE_WD-1-k] = 1'b1;
      k++;
      if (k == DATA_BYTE_WD || i == l - 1) begin
        b.last = (i == l - 1);
        exp_pay.push_back(b);
        b = '0;
        k = 0;
      end
    end
  endfunction

  task automatic send_pkt(input int h);
    int    l, nb, idx, wcnt;
    data_t d;
    keep_t kp;
    model(h);
    l  = pkt.size();
    nb = (l + DATA_BYTE_WD - 1) / DATA_BYTE_WD;
    for (int b = 0; b < nb; b++) begin
      if (rand_rdy && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      d  = '0;
      kp = '0;
      for (int j = 0; j < DATA_BYTE_WD; j++) begin
        idx = b * DATA_BYTE_WD + j;
        if (idx < l) begin
          d[8*(DATA_BYTE_WD-1-j) +: 8] = pkt[idx];
          kp[DATA_BYTE_WD-1-j] = 1'b1;
        end
      end
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      bus.keep_in  = kp;
      bus.last_in  = (b == nb - 1);
      if (b == 0) begin
        bus.valid_len_i = 1'b1;
        bus.len_i       = cnt_t'(h);
      end
      wcnt = 0;
      forever begin
        @(negedge clk);
        if (bus.ready_in) break;
        wcnt++;
        if (wcnt > 2000) begin
          n_tests++;
          n_fail++;
          $display("FAIL accept_timeout: beat %0d of packet not accepted in 2000 cycles", b);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $fatal(1, "input stalled");
        end
      end
      if (b == 0) chk("ready_len_o", 64'(bus.ready_len_o), 64'd1);
      @(posedge clk);
      #1;
      bus.valid_in    = 1'b0;
      bus.valid_len_i = 1'b0;
      bus.last_in     = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && c < 5000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_payload", 64'(exp_pay.size()), 64'd0);
    chk("drain_header", 64'(exp_hdr.size()), 64'd0);
  endtask

  // Readies change just after the active edge, so they are stable at the negedge.
  initial begin
    bus.ready_out   = 1'b1;
    bus.ready_hdr_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        bus.ready_out   = 1'($urandom_range(0, 1));
        bus.ready_hdr_i = 1'($urandom_range(0, 1));
      end else begin
        bus.ready_out   = 1'b1;
        bus.ready_hdr_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        pay_stall = 1'b0;
        hdr_stall = 1'b0;
      end else begin
        cur_pay = {bus.data_out, bus.keep_out, bus.last_out};
        if (pay_stall) begin
          chk("payload_hold_valid", 64'(bus.valid_out), 64'd1);
          chk("payload_hold_beat", 64'(cur_pay), 64'(held_pay));
        end
        pay_stall = 1'b0;
        if (bus.valid_out) begin
          if (bus.ready_out) begin
            if (exp_pay.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL payload_extra: got %h expected no beat", cur_pay);
            end else begin
              e_pay = exp_pay.pop_front();
              chk("payload_beat", 64'(cur_pay), 64'(e_pay));
            end
          end else begin
            pay_stall = 1'b1;
            held_pay  = cur_pay;
          end
        end
        if (hdr_stall) begin
          chk("header_hold_valid", 64'(bus.valid_hdr_o), 64'd1);
          chk("header_hold_data", 64'({bus.data_hdr_o, bus.keep_hdr_o}),
              64'({held_hdr.data, held_hdr.keep}));
        end
        hdr_stall = 1'b0;
        if (bus.valid_hdr_o) begin
          if (bus.ready_hdr_i) begin
            if (exp_hdr.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL header_extra: got %h expected no header", bus.data_hdr_o);
            end else begin
              e_hdr = exp_hdr.pop_front();
              chk("header", 64'({bus.data_hdr_o, bus.keep_hdr_o}), 64'({e_hdr.data, e_hdr.keep}));
            end
          end else begin
            hdr_stall     = 1'b1;
            held_hdr.data = bus.data_hdr_o;
            held_hdr.keep = bus.keep_hdr_o;
          end
        end
        if (bus.err_short_o) err_seen++;
      end
    end
  end

  initial begin
    int h, l;
    bus.valid_len_i = 1'b0;
    bus.len_i       = '0;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.keep_in     = '0;
    bus.last_in     = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_valid_hdr", 64'(bus.valid_hdr_o), 64'd0);
    chk("rst_err_short", 64'(bus.err_short_o), 64'd0);
    chk("rst_payload", 64'({bus.data_out, bus.keep_out, bus.last_out}), 64'd0);
    chk("rst_header", 64'({bus.data_hdr_o, bus.keep_hdr_o}), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(1);
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_pkt(3);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_pkt(4);
    pkt = '{8'hAA, 8'hBB};
    send_pkt(4);
    pkt = '{8'h5A, 8'h6B, 8'h7C};
    send_pkt(1);
    pkt = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    send_pkt(4);
    wait_drain();

    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      h = (p < 12) ? ((p % 2 == 0) ? 2 : 4) : int'($urandom_range(1, DATA_BYTE_WD));
      l = int'($urandom_range(1, 14));
      pkt.delete();
      for (int i = 0; i < l; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send_pkt(h);
    end
    wait_drain();
    rand_rdy = 1'b0;

    // Abort a packet mid-body with reset, then check a clean restart.
    @(posedge clk);
    #1;
    chk_en          = 1'b0;
    bus.valid_in    = 1'b1;
    bus.data_in     = 32'h0102_0304;
    bus.keep_in     = '1;
    bus.last_in     = 1'b0;
    bus.valid_len_i = 1'b1;
    bus.len_i       = cnt_t'(2);
    @(posedge clk);
    #1;
    bus.valid_len_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("midrst_valid_hdr", 64'(bus.valid_hdr_o), 64'd0);
    chk("midrst_err_short", 64'(bus.err_short_o), 64'd0);
    bus.valid_in = 1'b0;
    exp_pay.delete();
    exp_hdr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    pkt = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_pkt(2);
    wait_drain();

    chk("err_short_count", 64'(err_seen), 64'(err_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_extract_header.md
# axis_extract_header

Receive-side counterpart of the AXI-Stream header inserter. It strips a per-packet, variable-length header (1..DATA_BYTE_WD bytes) from the front of each incoming packet and returns it on a separate header channel. The remaining payload is realigned and forwarded as a contiguous, MSB-first stream with an MSB-aligned keep on the last beat. It sits at the stream ingress, before any payload consumer.

## Interface
- DATA_WD, 32, stream data width in bits; multiple of 8
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_len_i  in  1  header-length token valid
- len_i  in  BYTE_CNT_WD+1  header length H in bytes, legal 1..DATA_BYTE_WD
- ready_len_o  out  1  length token consumed
- valid_in  in  1  input beat valid
- data_in  in  DATA_WD  input data; byte DATA_BYTE_WD-1 (MSB) is first on the wire
- keep_in  in  DATA_BYTE_WD  all ones except on the last beat, which is MSB-aligned contiguous
- last_in  in  1  last beat of packet
- ready_in  out  1  input accepted
- valid_out / data_out / keep_out / last_out  out  1 / DATA_WD / DATA_BYTE_WD / 1  payload stream
- ready_out  in  1  payload sink ready
- valid_hdr_o  out  1  header valid
- data_hdr_o  out  DATA_WD  header, right-aligned (LSB bytes)
- keep_hdr_o  out  DATA_BYTE_WD  header byte mask, right-aligned
- ready_hdr_i  in  1  header sink ready
- err_short_o  out  1  one-cycle pulse: packet had no more than H bytes

## Operation
- FSM states are IDLE, BODY and FLUSH.
- IDLE:
  - ready_in = valid_len_i & header register free (empty, or draining this cycle) & payload stage able to accept.
  - On acceptance, H is latched, ready_len_o pulses for the same cycle and the length token is consumed.
  - The header is the top H bytes of the first beat, right-shifted by 8*(DATA_BYTE_WD-H). keep_hdr_o = (1<<H)-1.
  - The residue register takes the low DATA_BYTE_WD-H bytes of the first beat. No payload is emitted for this beat.
  - First beat last with n > H valid bytes: go to FLUSH.
  - First beat last with n ≤ H: the header keeps only the n bytes present; no payload is emitted; err_short_o pulses; return to IDLE.
  - Otherwise go to BODY.
- BODY, per accepted beat with n valid bytes:
  - Output = {residue, top H bytes of data_in}.
  - Residue is updated to the low DATA_BYTE_WD-H bytes.
  - On last_in with n ≤ H: output beat is last, keep = MSB-aligned (DATA_BYTE_WD-H+n) ones; go to IDLE.
  - On last_in with n > H: output beat is full; go to FLUSH.
- FLUSH:
  - ready_in = 0.
  - Emit {residue, zeros} with keep = MSB-aligned (n-H) ones and last_out = 1; go to IDLE.
- H = DATA_BYTE_WD is a degenerate but legal case: the payload is beats 2..N unchanged.
- Packets are never reordered or merged. A header is always emitted before or alongside the first payload beat of its packet.

## Timing
- All outputs are registered except ready_in and ready_len_o. Both of those are combinational from state, valid_len_i and the downstream readies; they must not depend on valid_in.
- Reset values:
  - valid_out, valid_hdr_o, last_out, err_short_o = 0; all data and keep outputs = 0.
  - State = IDLE.
  - Residue and latched H = 0.
- Payload latency: one cycle from acceptance of the contributing input beat to valid_out.
- Throughput: 1 beat per cycle in BODY under full ready. Each packet whose last beat has n > H costs one extra input stall cycle.
- The header is valid one cycle after first-beat acceptance. It holds until ready_hdr_i; a stalled header stalls the next packet only.
- Output valid/data/keep/last stay stable while valid & !ready. No combinational path from ready_out to valid_out.
- Asynchronous reset mid-packet discards everything. The first beat after reset is treated as a packet start.

## Structure
- The shared stream package holds the byte-mask helpers: MSB-aligned mask from count, right-aligned mask from count, and popcount of a contiguous keep.
- One sub-module, axis_reg_slice: a 1-entry registered valid/ready slice carrying {data, keep, last}. It is instantiated for the payload output.
- The header register and the FSM stay in the top module.

## Test plan
- DATA_WD=32, H=1; beats 0xAABBCCDD/F, 0x11223344/F last:
  - header 0x000000AA keep 0001
  - payload 0xBBCCDD11/F, then 0x22334400 keep 1110 last
- H=3; beats 0xAABBCCDD/F, 0x11220000 keep 1100 last:
  - header 0x00AABBCC keep 0111
  - payload 0xDD112200 keep 1110 last, no FLUSH
- H=4; three full beats, last keep 1000:
  - header = beat 1 keep 1111
  - payload = beats 2 and 3 unchanged, keep 1000 last
- H=4; single beat 0xAABB0000 keep 1100 last:
  - header 0x0000AABB keep 0011
  - err_short_o pulse, no payload
- Back-to-back packets with H=2 then H=4, random ready_out and ready_hdr_i at 50%:
  - byte-exact scoreboard, no loss or duplication
  - outputs stable under stall
- rst_n asserted mid-BODY:
  - all valids 0 immediately
  - next packet with H=2 is extracted correctly
